// File: rtl/bi_mem_wm_req_adapter.sv
// rtl/bi_mem_wm_req_adapter.sv - valid/ready request front-end for a write-masked (Wm) memory port
module bi_mem_wm_req_adapter #(
  parameter string PROFILE    = "default",
  parameter int    WIDTH      = 16,
  parameter int    HEIGHT     = 16,
  parameter int    MASK       = 4,
  parameter int    RESP_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_isWrite_i,
  input  logic [MASK-1:0]           req_mask_i,
  input  logic [$clog2(HEIGHT)-1:0] req_addr_i,
  input  logic [WIDTH-1:0]          req_data_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WIDTH-1:0]          rsp_data_o,
  output logic                      mem_enable_o,
  output logic                      mem_isWrite_o,
  output logic [MASK-1:0]           mem_writeMask_o,
  output logic [$clog2(HEIGHT)-1:0] mem_addr_o,
  output logic [WIDTH-1:0]          mem_writeData_o,
  input  logic [WIDTH-1:0]          mem_readData_i,
  input  logic                      mem_hold_i,
  output logic                      idle_o
);

  localparam int AW = $clog2(HEIGHT);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(RESP_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(RESP_DEPTH - 1);

  // Stage register: the one request currently presented to the memory
  logic             stg_v;
  logic             stg_is_write;
  logic [MASK-1:0]  stg_mask;
  logic [AW-1:0]    stg_addr;
  logic [WIDTH-1:0] stg_data;

  // A read fired last cycle; its data is on mem_readData_i now
  logic pend;

  // Response FIFO
  logic [WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [CW:0] occ;
  logic        credit_ok;
  logic        fire;
  logic        accept;
  logic        push;
  logic        pop;

  // Outstanding read slots: queued responses plus the one arriving now.
  // A pop in the same cycle is deliberately not credited back.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, pend};
  assign credit_ok = occ < DEPTH_OCC;

  assign mem_enable_o    = stg_v && (stg_is_write || credit_ok);
  assign mem_isWrite_o   = stg_is_write;
  assign mem_writeMask_o = stg_is_write ? stg_mask : '0;
  assign mem_addr_o      = stg_addr;
  assign mem_writeData_o = stg_data;

  assign fire        = mem_enable_o && !mem_hold_i;
  assign req_ready_o = !stg_v || fire;
  assign accept      = req_valid_i && req_ready_o;

  assign push        = pend;
  assign rsp_valid_o = count != '0;
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_data_o  = fifo_mem[rd_ptr];

  assign idle_o = !stg_v && !pend && (count == '0);

  // Stage load on acceptance, release on fire; held otherwise so mem_* stay stable under hold
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_v        <= 1'b0;
      stg_is_write <= 1'b0;
      stg_mask     <= '0;
      stg_addr     <= '0;
      stg_data     <= '0;
    end else if (accept) begin
      stg_v        <= 1'b1;
      stg_is_write <= req_isWrite_i;
      stg_mask     <= req_mask_i;
      stg_addr     <= req_addr_i;
      stg_data     <= req_data_i;
    end else if (fire) begin
      stg_v        <= 1'b0;
    end
  end

  // Read data returns exactly one cycle after a read fires
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend <= 1'b0;
    end else begin
      pend <= fire && !stg_is_write;
    end
  end

  // Response FIFO storage and pointers; push and pop may coincide
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_readData_i;
        wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // The credit rule leaves room for every returning read
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && count == DEPTH_CNT))
    else $error("response FIFO overflow (profile %s)", PROFILE);

endmodule

// File: tb/tb_bi_mem_wm_req_adapter.sv
// tb/tb_bi_mem_wm_req_adapter.sv - scoreboard bench with memory model for bi_mem_wm_req_adapter
module tb_bi_mem_wm_req_adapter;

  localparam int WIDTH      = 16;
  localparam int HEIGHT     = 16;
  localparam int MASK       = 4;
  localparam int RESP_DEPTH = 2;
  localparam int AW         = 4;
  localparam int LW         = WIDTH / MASK;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_is_write;
  logic [MASK-1:0]  req_mask;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             mem_enable, mem_is_write, mem_hold, idle;
  logic [MASK-1:0]  mem_mask;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  bi_mem_wm_req_adapter #(
    .PROFILE("default"), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_isWrite_i(req_is_write),
    .req_mask_i(req_mask), .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .mem_enable_o(mem_enable), .mem_isWrite_o(mem_is_write), .mem_writeMask_o(mem_mask),
    .mem_addr_o(mem_addr), .mem_writeData_o(mem_wdata), .mem_readData_i(mem_rdata),
    .mem_hold_i(mem_hold), .idle_o(idle)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int read_fires = 0;
  int write_fires = 0;
  int accepts = 0;
  int rsp_count = 0;
  int last_acc_cyc = 0;
  int inflight = 0;
  logic rand_mode = 1'b0;
  logic [WIDTH-1:0] last_rsp = '0;

  logic [WIDTH-1:0] mem_model [HEIGHT];
  logic [WIDTH-1:0] ref_mem   [HEIGHT];
  logic [WIDTH-1:0] exp_q [$];

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v,
                                             input logic [WIDTH-1:0] new_v,
                                             input logic [MASK-1:0]  m);
    logic [WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < MASK; i++)
      if (m[i]) r[i*LW +: LW] = new_v[i*LW +: LW];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  // Attached Wm memory: masked writes on fire, read data registered for the next cycle
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && mem_enable && !mem_hold) begin
      if (mem_is_write) begin
        mem_model[mem_addr] <= merge(mem_model[mem_addr], mem_wdata, mem_mask);
        write_fires <= write_fires + 1;
        mem_rdata   <= WIDTH'($urandom);
      end else begin
        mem_rdata  <= mem_model[mem_addr];
        read_fires <= read_fires + 1;
      end
    end else begin
      mem_rdata <= WIDTH'($urandom);
    end
  end

  // Random hold / response back-pressure while rand_mode is set
  initial forever begin
    @(posedge clk); #1;
    if (rand_mode) begin
      mem_hold  = ($urandom_range(0, 3) == 0);
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: reference model update on accept, scoreboard pop on response
  initial begin
    logic held;
    logic [31:0] prev_bus;
    held = 1'b0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 0;
        held = 1'b0;
      end else begin
        if (held)
          check("hold_stable", {6'd0, mem_enable, mem_is_write, mem_mask, mem_addr, mem_wdata}, prev_bus);
        held = mem_enable && mem_hold;
        prev_bus = {6'd0, mem_enable, mem_is_write, mem_mask, mem_addr, mem_wdata};
        if (req_valid && req_ready) begin
          accepts++;
          last_acc_cyc = cyc;
          if (req_is_write) ref_mem[req_addr] = merge(ref_mem[req_addr], req_data, req_mask);
          else exp_q.push_back(ref_mem[req_addr]);
        end
        if (mem_enable && !mem_hold && !mem_is_write) begin
          inflight++;
          check("credit_bound", 32'(inflight <= RESP_DEPTH), 32'd1);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %0h expected no response", rsp_data);
          end else begin
            check("rsp_data", rsp_data, exp_q.pop_front());
          end
          last_rsp = rsp_data;
          inflight--;
          rsp_count++;
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send(input logic w, input logic [MASK-1:0] m, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d);
    req_valid = 1'b1;
    req_is_write = w;
    req_mask = m;
    req_addr = a;
    req_data = d;
    wait_accept();
  endtask

  task automatic wait_idle();
    int n;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(idle && exp_q.size() == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(idle && exp_q.size() == 0)) fail("idle_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    int rf0, wf0, r0, first_acc, n, lat;
    for (int i = 0; i < HEIGHT; i++) begin
      mem_model[i] = WIDTH'($urandom);
      ref_mem[i]   = mem_model[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_is_write = 1'b0; req_mask = '0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_mask", mem_mask, 0);
    check("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Write then read back, with latency measurement
    rf0 = read_fires; wf0 = write_fires; r0 = rsp_count;
    send(1'b1, 4'b1111, 4'd3, 16'hA5A5);
    send(1'b0, 4'b0000, 4'd3, 16'h0000);
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    lat = cyc - last_acc_cyc;
    check("read_latency", lat, 3);
    wait_idle();
    check("t1_rsp_data", last_rsp, 16'hA5A5);
    check("t1_write_fires", write_fires - wf0, 1);
    check("t1_read_fires", read_fires - rf0, 1);
    check("t1_rsp_count", rsp_count - r0, 1);

    // Partial-mask write merge
    send(1'b1, 4'b1111, 4'd5, 16'h1234);
    send(1'b1, 4'b0011, 4'd5, 16'hFFFF);
    send(1'b0, 4'b0000, 4'd5, 16'h0000);
    wait_idle();
    check("t2_merge", last_rsp, 16'h12FF);

    // Hold for 4 cycles on a staged write
    mem_hold = 1'b1;
    wf0 = write_fires;
    send(1'b1, 4'b0101, 4'd7, 16'hBEEF);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_bus", {mem_enable, mem_is_write, mem_mask, mem_addr, mem_wdata},
            {1'b1, 1'b1, 4'b0101, 4'd7, 16'hBEEF});
      check("hold_ready", req_ready, 0);
    end
    check("hold_no_fire", write_fires - wf0, 0);
    @(posedge clk); #1;
    mem_hold = 1'b0;
    wait_idle();
    check("hold_single_fire", write_fires - wf0, 1);

    // Credit throttling with a stalled response consumer
    rsp_ready = 1'b0;
    rf0 = read_fires; r0 = rsp_count;
    send(1'b0, 4'b0000, 4'd3, 16'h0);
    send(1'b0, 4'b0000, 4'd5, 16'h0);
    send(1'b0, 4'b0000, 4'd7, 16'h0);
    req_valid = 1'b1; req_is_write = 1'b0; req_addr = 4'd3;
    repeat (5) @(negedge clk);
    check("credit_fires", read_fires - rf0, 2);
    check("credit_enable", mem_enable, 0);
    check("credit_ready", req_ready, 0);
    check("credit_rmask", mem_mask, 0);
    check("credit_rsp_valid", rsp_valid, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept();
    wait_idle();
    check("credit_fires_all", read_fires - rf0, 4);
    check("credit_rsp_count", rsp_count - r0, 4);

    // Back-to-back alternating write/read stream
    r0 = rsp_count;
    first_acc = 0;
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = AW'(i * 3 + 1);
      if (i % 2 == 0) send(1'b1, 4'($urandom), a, WIDTH'($urandom));
      else send(1'b0, 4'b0000, AW'((i - 1) * 3 + 1), 16'h0);
      if (i == 0) first_acc = last_acc_cyc;
    end
    req_valid = 1'b0;
    check("b2b_span", last_acc_cyc - first_acc, 7);
    wait_idle();
    check("b2b_rsp_count", rsp_count - r0, 4);

    // Reset while a read is returning
    send(1'b1, 4'b1111, 4'd9, 16'h5A3C);
    wait_idle();
    send(1'b0, 4'b0000, 4'd9, 16'h0);
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_enable && !mem_hold && !mem_is_write) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("rst_read_fire");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_idle", idle, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_enable", mem_enable, 0);
    exp_q.delete();
    r0 = rsp_count;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_rsp", rsp_count - r0, 0);
    check("rst_no_valid", rsp_valid, 0);
    @(posedge clk); #1;
    send(1'b0, 4'b0000, 4'd9, 16'h0);
    wait_idle();
    check("rst_after_read", last_rsp, 16'h5A3C);

    // Randomized traffic under random hold and back-pressure
    r0 = accepts;
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom), WIDTH'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    rand_mode = 1'b0;
    mem_hold = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("rand_accepts", accepts - r0, 300);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
